core_sequencer: RTL and testbench
=================================

# core_sequencer

Multi-cycle control FSM for the RV32IM core. It steps the fetch, decode, execute, memory and write-back stages one at a time by driving their stage enables, including the decode stage's `enabled` input. It waits on the instruction-memory, data-memory and mul/div handshakes, takes traps for illegal/ecall/ebreak/memory-timeout, selects the next-PC source, and keeps the cycle and retired-instruction counters read by the CSR file.

## Interface
Parameters:
- `MEM_TIMEOUT`, 255: max cycles waiting for `dmem_ready` in MEM before an access-fault trap; legal range 1..65535.

Ports:
- `clk`  in  1  core clock; all state changes on rising edge
- `rst`  in  1  reset; **synchronous, active-high**
- `imem_ready`  in  1  instruction word valid this cycle
- `dmem_ready`  in  1  data access complete this cycle
- `is_load`, `is_store`  in  1  decoded class flags, valid while in EXEC
- `is_muldiv`  in  1  decoded mul/div/rem instruction
- `muldiv_done`  in  1  mul/div unit result ready
- `is_illegal_instr`, `ecall`, `ebreak`, `mret`  in  1  decoded flags
- `branch_taken`  in  1  execute stage resolved a taken branch, jal or jalr; sampled in WB
- `fetch_en`, `decode_en`, `exec_en`, `mem_en`, `wb_en`  out  1  stage enables, one-hot or all zero
- `pc_we`  out  1  PC register load strobe
- `pc_sel`  out  2  0 = pc+4, 1 = branch target, 2 = trap vector (mtvec), 3 = mepc
- `trap_take`  out  1  one-cycle pulse: CSR file latches mepc/mcause
- `trap_cause`  out  4  mcause code, valid with `trap_take`
- `cycle_cnt`  out  64  cycles since reset release
- `instret_cnt`  out  64  retired instructions

## Operation
- **States:** IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP. Registered state; all outputs decode from state, except `pc_sel` in WB, which also depends on inputs.
- **IDLE:** entered on reset. All outputs 0, counters 0. Next cycle goes to FETCH unconditionally.
- **FETCH:** `fetch_en`=1. Stays until `imem_ready`=1, then goes to DECODE.
- **DECODE:** `decode_en`=1 for exactly one cycle, then EXEC. Decoded flags are valid from the first EXEC cycle.
- **EXEC:** `exec_en`=1. Priority, highest first:
  - `is_illegal_instr` → TRAP, cause 2
  - `ecall` → TRAP, cause 11
  - `ebreak` → TRAP, cause 3
  - `is_muldiv` && !`muldiv_done` → stay in EXEC
  - `is_load` or `is_store` → MEM
  - otherwise → WB
  - `muldiv_done` arriving together with a trap flag is ignored; the trap wins.
- **MEM:** `mem_en`=1. The timeout counter clears on entry and increments each cycle `dmem_ready`=0.
  - `dmem_ready`=1 → WB. Ready wins over timeout if both occur in the same cycle.
  - Counter reaches `MEM_TIMEOUT` → TRAP, cause 5 if load, 7 if store.
- **WB:** `wb_en`=1, `pc_we`=1, `instret_cnt`+1, then FETCH. `pc_sel` priority:
  - `mret` → 3
  - `branch_taken` → 1
  - otherwise → 0
- **TRAP:** `trap_take`=1, `pc_we`=1, `pc_sel`=2, `trap_cause` from the latched code, then FETCH. `instret_cnt` is not incremented.
- The trap cause register is loaded on the EXEC/MEM exit edge. It holds its value otherwise and is 0 at reset.
- **Counters:** `cycle_cnt` increments every cycle in any state except IDLE and reset. Both counters wrap modulo 2^64 with no flag.
- **Reset:** `rst` asserted in any state → next edge gives IDLE, with all outputs and counters 0. An in-flight instruction is abandoned with no retire and no trap.

## Timing
- **Reset values:**
  - All enables, `pc_we` and `trap_take`: 0
  - `pc_sel`: 0
  - `trap_cause`: 0
  - Both counters: 0
- **Minimum latency, FETCH entry to next FETCH, zero wait states:**
  - ALU/branch: 4 cycles (F, D, E, W)
  - Load/store: 5 cycles
  - Trap: 4 cycles (F, D, E, T)
- Each FETCH wait cycle and each mul/div wait cycle adds exactly 1 cycle.
- A MEM timeout trap occurs `MEM_TIMEOUT` cycles after MEM entry.
- `imem_ready`, `dmem_ready` and `muldiv_done` are level-sampled. They are only meaningful in their own state and ignored elsewhere.
- Exactly one stage enable is high per cycle outside IDLE and TRAP. All enables are 0 in IDLE and TRAP.

## Test plan
- **Reset release, addi:** release `rst`, `imem_ready`=1 constantly → IDLE, then F/D/E/W on cycles 1-4; `pc_we`=1 with `pc_sel`=0 on cycle 4; `instret_cnt`=1, `cycle_cnt`=4 after the WB edge.
- **Load with wait states:** `is_load`=1, `dmem_ready` high on the 3rd MEM cycle → `mem_en` high 3 cycles, then WB; total 7 cycles; `instret_cnt`+1.
- **Mul/div stall:** `is_muldiv`=1, `muldiv_done` after 33 EXEC cycles → `exec_en` high 33 cycles, then WB; `pc_sel`=0.
- **Illegal plus ecall in the same cycle:** EXEC with `is_illegal_instr`=1, `ecall`=1 → TRAP, `trap_take` pulse, `trap_cause`=2, `pc_sel`=2; `instret_cnt` unchanged.
- **Store timeout, `MEM_TIMEOUT`=4:** `is_store`=1, `dmem_ready`=0 → TRAP after 4 MEM cycles, cause 7. Second case: `dmem_ready`=1 exactly on the 4th cycle → WB instead, no trap.
- **Mid-MEM reset and mret:** assert `rst` on the 2nd MEM cycle → next edge gives IDLE with all outputs and counters 0. After restart, WB with `mret`=1 and `branch_taken`=1 → `pc_sel`=3.

Source files
------------

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle control FSM for the RV32IM core.
// Steps FETCH -> DECODE -> EXEC -> [MEM] -> WB one stage at a time, waits on
// the imem/dmem/muldiv handshakes, and takes traps for illegal, ecall,
// ebreak and data-memory timeout. It also keeps the cycle and retired-
// instruction counters that the CSR file reads.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   imem_ready, dmem_ready        memory handshakes (level-sampled)
//   is_load, is_store, is_muldiv  decoded class flags, valid in EXEC
//   muldiv_done                   mul/div result ready
//   is_illegal_instr, ecall,
//   ebreak, mret                  decoded flags
//   branch_taken                  taken branch/jump, sampled in WB
//   fetch_en..wb_en               stage enables (one-hot or all zero)
//   pc_we, pc_sel                 PC load strobe and source select
//   trap_take, trap_cause         one-cycle trap pulse and mcause code
//   cycle_cnt, instret_cnt        64-bit cycle / retired counters
module core_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    input  logic        is_load,
    input  logic        is_store,
    input  logic        is_muldiv,
    input  logic        muldiv_done,
    input  logic        is_illegal_instr,
    input  logic        ecall,
    input  logic        ebreak,
    input  logic        mret,
    input  logic        branch_taken,
    output logic        fetch_en,
    output logic        decode_en,
    output logic        exec_en,
    output logic        mem_en,
    output logic        wb_en,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        trap_take,
    output logic [3:0]  trap_cause,
    output logic [63:0] cycle_cnt,
    output logic [63:0] instret_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } state_t;

    localparam logic [3:0] CAUSE_ILLEGAL  = 4'd2;
    localparam logic [3:0] CAUSE_EBREAK   = 4'd3;
    localparam logic [3:0] CAUSE_LD_FAULT = 4'd5;
    localparam logic [3:0] CAUSE_ST_FAULT = 4'd7;
    localparam logic [3:0] CAUSE_ECALL    = 4'd11;

    // The counter holds the number of not-ready MEM cycles already elapsed,
    // so a timeout fires on the cycle whose miss would bring it to MEM_TIMEOUT.
    localparam logic [15:0] MEM_LIMIT = 16'(MEM_TIMEOUT - 1);

    state_t      state;
    state_t      next_state;
    logic [15:0] mem_cnt;
    logic        mem_is_load;
    logic [3:0]  cause_q;
    logic [3:0]  cause_d;
    logic        cause_load;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    // Next-state logic, plus the trap code captured on the EXEC/MEM exit edge
    always_comb begin
        next_state = state;
        cause_load = 1'b0;
        cause_d    = '0;
        case (state)
            S_IDLE:   next_state = S_FETCH;
            S_FETCH:  if (imem_ready) next_state = S_DECODE;
            S_DECODE: next_state = S_EXEC;
            S_EXEC: begin
                if (is_illegal_instr) begin
                    next_state = S_TRAP;
                    cause_load = 1'b1;
                    cause_d    = CAUSE_ILLEGAL;
                end else if (ecall) begin
                    next_state = S_TRAP;
                    cause_load = 1'b1;
                    cause_d    = CAUSE_ECALL;
                end else if (ebreak) begin
                    next_state = S_TRAP;
                    cause_load = 1'b1;
                    cause_d    = CAUSE_EBREAK;
                end else if (is_muldiv && !muldiv_done) begin
                    next_state = S_EXEC;
                end else if (is_load || is_store) begin
                    next_state = S_MEM;
                end else begin
                    next_state = S_WB;
                end
            end
            S_MEM: begin
                if (dmem_ready) begin
                    next_state = S_WB;
                end else if (mem_cnt == MEM_LIMIT) begin
                    next_state = S_TRAP;
                    cause_load = 1'b1;
                    cause_d    = mem_is_load ? CAUSE_LD_FAULT : CAUSE_ST_FAULT;
                end
            end
            S_WB:     next_state = S_FETCH;
            S_TRAP:   next_state = S_FETCH;
            default:  next_state = S_IDLE;
        endcase
    end

    // Output decode; pc_sel in WB is the only input-dependent output
    always_comb begin
        fetch_en   = 1'b0;
        decode_en  = 1'b0;
        exec_en    = 1'b0;
        mem_en     = 1'b0;
        wb_en      = 1'b0;
        pc_we      = 1'b0;
        pc_sel     = 2'd0;
        trap_take  = 1'b0;
        trap_cause = '0;
        case (state)
            S_FETCH:  fetch_en  = 1'b1;
            S_DECODE: decode_en = 1'b1;
            S_EXEC:   exec_en   = 1'b1;
            S_MEM:    mem_en    = 1'b1;
            S_WB: begin
                wb_en = 1'b1;
                pc_we = 1'b1;
                if (mret)              pc_sel = 2'd3;
                else if (branch_taken) pc_sel = 2'd1;
                else                   pc_sel = 2'd0;
            end
            S_TRAP: begin
                trap_take  = 1'b1;
                pc_we      = 1'b1;
                pc_sel     = 2'd2;
                trap_cause = cause_q;
            end
            default: ;
        endcase
    end

    // MEM bookkeeping: the load/store class is captured while in EXEC since
    // the decoded flags are only guaranteed valid there.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_cnt     <= '0;
            mem_is_load <= 1'b0;
        end else begin
            if (state == S_EXEC) mem_is_load <= is_load;
            if (state != S_MEM)  mem_cnt <= '0;
            else if (!dmem_ready) mem_cnt <= mem_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)             cause_q <= '0;
        else if (cause_load) cause_q <= cause_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (state != S_IDLE) cycle_cnt   <= cycle_cnt + 64'd1;
            if (state == S_WB)   instret_cnt <= instret_cnt + 64'd1;
        end
    end

endmodule

// File: tb/tb_core_sequencer.sv
// Testbench for core_sequencer: each instruction is described abstractly
// (fetch waits, class, mul/div and memory waits, trap flags, PC flags) and
// expanded into the per-cycle list of expected stage outputs and counters.
module tb_core_sequencer;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_ready = 1'b0, dmem_ready = 1'b0;
    logic        is_load = 1'b0, is_store = 1'b0, is_muldiv = 1'b0, muldiv_done = 1'b0;
    logic        is_illegal_instr = 1'b0, ecall = 1'b0, ebreak = 1'b0, mret = 1'b0;
    logic        branch_taken = 1'b0;
    logic        fetch_en, decode_en, exec_en, mem_en, wb_en, pc_we, trap_take;
    logic [1:0]  pc_sel;
    logic [3:0]  trap_cause;
    logic [63:0] cycle_cnt, instret_cnt;

    core_sequencer #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .is_load(is_load), .is_store(is_store),
        .is_muldiv(is_muldiv), .muldiv_done(muldiv_done),
        .is_illegal_instr(is_illegal_instr), .ecall(ecall), .ebreak(ebreak),
        .mret(mret), .branch_taken(branch_taken),
        .fetch_en(fetch_en), .decode_en(decode_en), .exec_en(exec_en),
        .mem_en(mem_en), .wb_en(wb_en), .pc_we(pc_we), .pc_sel(pc_sel),
        .trap_take(trap_take), .trap_cause(trap_cause),
        .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    always #5 clk = ~clk;

    // cls: 0 = alu/branch, 1 = load, 2 = store, 3 = mul/div
    typedef struct {
        int fw;
        int cls;
        int md;
        int mw;
        bit ill, ec, eb, mr, br;
    } desc_t;

    // out = {fetch,decode,exec,mem,wb,pc_we,pc_sel[1:0],trap_take,trap_cause[3:0]}
    typedef struct {
        logic [12:0] out;
        logic        imem, dmem, mdone;
        bit          retire;
    } step_t;

    step_t   q[$];
    int      checks = 0;
    int      failures = 0;
    longint unsigned cyc = 0;
    longint unsigned ret = 0;

    function automatic step_t mk(logic [4:0] en, logic pcwe, logic [1:0] sel,
                                 logic trap, logic [3:0] cause, bit retire);
        step_t s;
        s.out    = {en, pcwe, sel, trap, cause};
        s.imem   = 1'($urandom);
        s.dmem   = 1'($urandom);
        s.mdone  = 1'($urandom);
        s.retire = retire;
        return s;
    endfunction

    task automatic build(input desc_t d);
        step_t s;
        bit    trap;
        int    n;
        q.delete();
        for (int i = 0; i <= d.fw; i++) begin
            s = mk(5'b10000, 0, 0, 0, 0, 0);
            s.imem = (i == d.fw);
            q.push_back(s);
        end
        q.push_back(mk(5'b01000, 0, 0, 0, 0, 0));
        trap = d.ill || d.ec || d.eb;
        if (trap) begin
            q.push_back(mk(5'b00100, 0, 0, 0, 0, 0));
            q.push_back(mk(5'b00000, 1, 2, 1, d.ill ? 4'd2 : (d.ec ? 4'd11 : 4'd3), 0));
            return;
        end
        if (d.cls == 3) begin
            for (int i = 0; i <= d.md; i++) begin
                s = mk(5'b00100, 0, 0, 0, 0, 0);
                s.mdone = (i == d.md);
                q.push_back(s);
            end
        end else begin
            q.push_back(mk(5'b00100, 0, 0, 0, 0, 0));
        end
        if (d.cls == 1 || d.cls == 2) begin
            n = (d.mw < TO) ? d.mw + 1 : TO;
            for (int i = 0; i < n; i++) begin
                s = mk(5'b00010, 0, 0, 0, 0, 0);
                s.dmem = (i == d.mw);
                q.push_back(s);
            end
            if (d.mw >= TO) begin
                q.push_back(mk(5'b00000, 1, 2, 1, (d.cls == 1) ? 4'd5 : 4'd7, 0));
                return;
            end
        end
        q.push_back(mk(5'b00001, 1, d.mr ? 2'd3 : (d.br ? 2'd1 : 2'd0), 0, 0, 1));
    endtask

    task automatic run_instr(input string name, input desc_t d, input int limit);
        logic [12:0] act;
        build(d);
        for (int k = 0; k < q.size() && k < limit; k++) begin
            @(negedge clk);
            is_load          = (d.cls == 1);
            is_store         = (d.cls == 2);
            is_muldiv        = (d.cls == 3);
            is_illegal_instr = d.ill;
            ecall            = d.ec;
            ebreak           = d.eb;
            mret             = d.mr;
            branch_taken     = d.br;
            imem_ready       = q[k].imem;
            dmem_ready       = q[k].dmem;
            muldiv_done      = q[k].mdone;
            #1;
            act = {fetch_en, decode_en, exec_en, mem_en, wb_en, pc_we, pc_sel, trap_take, trap_cause};
            checks++;
            if (act !== q[k].out) begin
                failures++;
                $display("FAIL %s outputs step %0d: got %b want %b", name, k, act, q[k].out);
            end
            checks++;
            if (cycle_cnt !== cyc) begin
                failures++;
                $display("FAIL %s cycle_cnt step %0d: got %0d want %0d", name, k, cycle_cnt, cyc);
            end
            checks++;
            if (instret_cnt !== ret) begin
                failures++;
                $display("FAIL %s instret_cnt step %0d: got %0d want %0d", name, k, instret_cnt, ret);
            end
            cyc++;
            if (q[k].retire) ret++;
        end
    endtask

    function automatic desc_t plain(int cls);
        desc_t d;
        d.fw = 0; d.cls = cls; d.md = 0; d.mw = 0;
        d.ill = 0; d.ec = 0; d.eb = 0; d.mr = 0; d.br = 0;
        return d;
    endfunction

    task automatic test_reset(input string name);
        logic [12:0] act;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        act = {fetch_en, decode_en, exec_en, mem_en, wb_en, pc_we, pc_sel, trap_take, trap_cause};
        checks++;
        if (act !== 13'd0) begin
            failures++;
            $display("FAIL %s outputs: got %b want 0", name, act);
        end
        checks++;
        if (cycle_cnt !== 64'd0 || instret_cnt !== 64'd0) begin
            failures++;
            $display("FAIL %s counters: got %0d/%0d want 0/0", name, cycle_cnt, instret_cnt);
        end
        rst = 1'b0;
        cyc = 0;
        ret = 0;
    endtask

    task automatic test_addi();
        test_reset("reset_release");
        run_instr("addi", plain(0), 1000);
        @(negedge clk);
        imem_ready = 1'b0;
        #1;
        checks++;
        if (cycle_cnt !== 64'd4 || instret_cnt !== 64'd1 || fetch_en !== 1'b1) begin
            failures++;
            $display("FAIL addi_counters: got cyc=%0d ret=%0d fetch=%b want 4 1 1",
                     cycle_cnt, instret_cnt, fetch_en);
        end
        cyc++;
    endtask

    task automatic test_load_wait();
        desc_t d = plain(1);
        d.mw = 2;
        run_instr("load_wait", d, 1000);
    endtask

    task automatic test_muldiv();
        desc_t d = plain(3);
        d.md = 32;
        run_instr("muldiv_stall", d, 1000);
    endtask

    task automatic test_illegal_ecall();
        desc_t d = plain(3);
        d.ill = 1; d.ec = 1;
        run_instr("illegal_ecall", d, 1000);
        d = plain(0);
        d.ec = 1; d.eb = 1;
        run_instr("ecall_ebreak", d, 1000);
        d = plain(1);
        d.eb = 1;
        run_instr("ebreak", d, 1000);
    endtask

    task automatic test_store_timeout();
        desc_t d = plain(2);
        d.mw = 10;
        run_instr("store_timeout", d, 1000);
        d.mw = 3;
        run_instr("store_ready_at_limit", d, 1000);
        d = plain(1);
        d.mw = 7;
        run_instr("load_timeout", d, 1000);
    endtask

    task automatic test_mid_mem_reset_mret();
        desc_t d = plain(1);
        d.mw = 10;
        run_instr("mid_mem_load", d, 4);
        test_reset("mid_mem_reset");
        d = plain(0);
        d.mr = 1; d.br = 1;
        run_instr("mret_over_branch", d, 1000);
        d = plain(0);
        d.br = 1; d.fw = 2;
        run_instr("branch", d, 1000);
    endtask

    task automatic test_back_to_back();
        desc_t d;
        for (int i = 0; i < 80; i++) begin
            d = plain($urandom_range(0, 3));
            d.fw = $urandom_range(0, 3);
            d.md = $urandom_range(0, 5);
            d.mw = $urandom_range(0, 5);
            d.mr = 1'($urandom);
            d.br = 1'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                d.ill = 1'($urandom);
                d.ec  = 1'($urandom);
                d.eb  = !(d.ill || d.ec) || 1'($urandom);
            end
            run_instr("random", d, 1000);
        end
    endtask

    initial begin
        test_reset("reset");
        test_addi();
        test_load_wait();
        test_muldiv();
        test_illegal_ecall();
        test_store_timeout();
        test_mid_mem_reset_mret();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
